mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4, range 1..15: max consecutive grants to one master while the other master requests.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have, per master x in {0,1}: i_mx_req  input  1  access request, held until granted.
REQ-005 SHALL have i_mx_addr  input  30  word address.
REQ-006 SHALL have i_mx_data  input  32  write data.
REQ-007 SHALL have i_mx_mask  input  4  byte-enable mask.
REQ-008 SHALL have i_mx_wren  input  1  1 = write, 0 = read.
REQ-009 SHALL have o_mx_gnt  output  1  access issued this cycle.
REQ-010 SHALL have o_mx_rvalid  output  1  read data valid.
REQ-011 SHALL have o_mx_rdata  output  32  read data.
REQ-012 SHALL have slave-side ports: o_mmio_addr  output  30;  o_mmio_data  output  32;  o_mmio_mask  output  4;  o_mmio_wren  output  1;  o_mmio_valid  output  1 (access issued);  i_mmio_data  input  32 (read data, valid one cycle after issue).

Function
REQ-013 SHALL hold state: fsm {IDLE, OWN0, OWN1}, last_gnt (1 bit), burst count cnt (4 bits), rd_pend (1 bit), rd_tag (1 bit).
REQ-014 SHALL compute grant combinationally in the request cycle; at most one o_mx_gnt high per cycle; gnt never high without matching req.
REQ-015 Single requester: SHALL grant it regardless of state.
REQ-016 Both request, fsm=IDLE: SHALL grant master != last_gnt.
REQ-017 Both request, fsm=OWNx, cnt<HOLD_MAX: SHALL grant x; cnt==HOLD_MAX: SHALL grant the other master.
REQ-018 On grant to x: fsm->OWNx, last_gnt<=x; cnt<=cnt+1 saturating at HOLD_MAX if fsm was OWNx, else cnt<=1.
REQ-019 No request: fsm->IDLE, cnt<=0, last_gnt unchanged.
REQ-020 Granted cycle: o_mmio_addr/data/mask/wren SHALL equal the granted master's inputs, o_mmio_valid=1 (zero-cycle combinational path).
REQ-021 Non-granted cycle: o_mmio_addr/data/mask SHALL be 0, o_mmio_wren=0, o_mmio_valid=0.
REQ-022 Granted read (wren=0): rd_pend<=1, rd_tag<=x; otherwise rd_pend<=0.
REQ-023 rd_pend=1: o_m{rd_tag}_rvalid=1 and o_m{rd_tag}_rdata=i_mmio_data for exactly one cycle; other master rvalid=0, rdata=0.
REQ-024 rd_pend=0: both rvalid=0, both rdata=0.
REQ-025 Back-to-back reads (same or alternating masters) SHALL return each datum in order, one per cycle, no bubbles.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 HOLD_MAX=1 with both requesting continuously SHALL yield strict alternation.

Reset
REQ-028 rst_n low SHALL immediately, asynchronously set fsm=IDLE, last_gnt=1, cnt=0, rd_pend=0, rd_tag=0.
REQ-029 During reset all outputs SHALL be 0 (gnt, rvalid, rdata, all o_mmio_*), independent of requests.
REQ-030 Read granted in the cycle before reset assertion SHALL NOT produce rvalid after release.
REQ-031 First cycle after release with both requesting SHALL grant m0.

Verification
REQ-032 Reset release, both req, wren=1, HOLD_MAX=4 -> grants m0,m0,m0,m0,m1,m1,m1,m1,m0...; o_mmio_valid=1 every cycle.
REQ-033 m1 alone reads addr 0x10, i_mmio_data=0xDEADBEEF next cycle -> o_m1_rvalid=1, o_m1_rdata=0xDEADBEEF one cycle after gnt; o_m0_rvalid=0.
REQ-034 m0 writes addr 0x3, data 0x12345678, mask 4'b0011 -> same cycle o_mmio_addr=0x3, data=0x12345678, mask=0011, wren=1; no rvalid.
REQ-035 m0 granted twice, one idle cycle, both req -> m1 granted (last_gnt=0, fsm IDLE).
REQ-036 m0 read granted, rst_n low next cycle for 2 cycles -> no rvalid at any time; after release both req -> m0 granted.
REQ-037 HOLD_MAX=1, alternating reads from both masters with i_mmio_data incrementing -> rvalid alternates m0/m1 each cycle, each rdata matches its issue cycle+1.

Source files
------------

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter with bounded burst ownership.
// Combinational grant/mux, one-cycle read data return routing.
module mmio_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_req,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_mask,
  input  logic        i_m0_wren,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_mask,
  input  logic        i_m1_wren,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [29:0] o_mmio_addr,
  output logic [31:0] o_mmio_data,
  output logic [3:0]  o_mmio_mask,
  output logic        o_mmio_wren,
  output logic        o_mmio_valid,
  input  logic [31:0] i_mmio_data
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } fsm_e;

  localparam logic [3:0] HMAX = 4'(HOLD_MAX);

  fsm_e       fsm_q, fsm_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_tag_q, rd_tag_d;

  logic g0, g1, sel1, at_max, wren_g;
  logic [3:0] cnt_inc;

  assign at_max  = (cnt_q >= HMAX);
  assign cnt_inc = at_max ? HMAX : cnt_q + 4'd1;

  // Contention winner: sel1 = 1 picks master 1
  always_comb begin
    sel1 = ~last_q;
    unique case (fsm_q)
      IDLE:    sel1 = ~last_q;
      OWN0:    sel1 = at_max;
      OWN1:    sel1 = ~at_max;
      default: sel1 = ~last_q;
    endcase
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (i_m0_req & ~i_m1_req): g0 = 1'b1;
        (~i_m0_req & i_m1_req): g1 = 1'b1;
        (i_m0_req & i_m1_req): begin
          g0 = ~sel1;
          g1 = sel1;
        end
        default: ;
      endcase
    end
  end

  assign wren_g = (g0 & i_m0_wren) | (g1 & i_m1_wren);

  always_comb begin
    fsm_d     = fsm_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_pend_d = (g0 | g1) & ~wren_g;
    rd_tag_d  = rd_tag_q;
    unique case (1'b1)
      g0: begin
        fsm_d    = OWN0;
        last_d   = 1'b0;
        cnt_d    = (fsm_q == OWN0) ? cnt_inc : 4'd1;
        rd_tag_d = 1'b0;
      end
      g1: begin
        fsm_d    = OWN1;
        last_d   = 1'b1;
        cnt_d    = (fsm_q == OWN1) ? cnt_inc : 4'd1;
        rd_tag_d = 1'b1;
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign o_m0_gnt     = g0;
  assign o_m1_gnt     = g1;
  assign o_mmio_valid = g0 | g1;
  assign o_mmio_wren  = wren_g;
  assign o_mmio_addr  = ({30{g0}} & i_m0_addr)
                      | ({30{g1}} & i_m1_addr);
  assign o_mmio_data  = ({32{g0}} & i_m0_data)
                      | ({32{g1}} & i_m1_data);
  assign o_mmio_mask  = ({4{g0}} & i_m0_mask)
                      | ({4{g1}} & i_m1_mask);

  assign o_m0_rvalid = rst_n & rd_pend_q & ~rd_tag_q;
  assign o_m1_rvalid = rst_n & rd_pend_q & rd_tag_q;
  assign o_m0_rdata  = {32{o_m0_rvalid}} & i_mmio_data;
  assign o_m1_rdata  = {32{o_m1_rvalid}} & i_mmio_data;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: HOLD_MAX=4 and HOLD_MAX=1 instances
// driven in parallel, checked against a streak-based model.
module tb_mmio_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0 = 0, r1 = 0, w0 = 0, w1 = 0;
  logic [29:0] a0 = 0, a1 = 0;
  logic [31:0] d0 = 0, d1 = 0, sd = 0;
  logic [3:0]  m0 = 0, m1 = 0;

  logic [1:0] g0, g1, rv0, rv1, wr, vl;
  logic [1:0][31:0] rd0, rd1, md;
  logic [1:0][29:0] ma;
  logic [1:0][3:0]  mm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_arbiter #(.HOLD_MAX(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(r0), .i_m0_addr(a0), .i_m0_data(d0),
    .i_m0_mask(m0), .i_m0_wren(w0),
    .o_m0_gnt(g0[0]), .o_m0_rvalid(rv0[0]),
    .o_m0_rdata(rd0[0]),
    .i_m1_req(r1), .i_m1_addr(a1), .i_m1_data(d1),
    .i_m1_mask(m1), .i_m1_wren(w1),
    .o_m1_gnt(g1[0]), .o_m1_rvalid(rv1[0]),
    .o_m1_rdata(rd1[0]),
    .o_mmio_addr(ma[0]), .o_mmio_data(md[0]),
    .o_mmio_mask(mm[0]), .o_mmio_wren(wr[0]),
    .o_mmio_valid(vl[0]), .i_mmio_data(sd)
  );

  mmio_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(r0), .i_m0_addr(a0), .i_m0_data(d0),
    .i_m0_mask(m0), .i_m0_wren(w0),
    .o_m0_gnt(g0[1]), .o_m0_rvalid(rv0[1]),
    .o_m0_rdata(rd0[1]),
    .i_m1_req(r1), .i_m1_addr(a1), .i_m1_data(d1),
    .i_m1_mask(m1), .i_m1_wren(w1),
    .o_m1_gnt(g1[1]), .o_m1_rvalid(rv1[1]),
    .o_m1_rdata(rd1[1]),
    .o_mmio_addr(ma[1]), .o_mmio_data(md[1]),
    .o_mmio_mask(mm[1]), .o_mmio_wren(wr[1]),
    .o_mmio_valid(vl[1]), .i_mmio_data(sd)
  );

  // Model: who was granted last, how many in a row, was last cycle idle
  int  hold [2] = '{4, 1};
  int  lastm [2];
  int  streak [2];
  bit  idlep [2];
  int  pend [2];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int pick(int k);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (idlep[k]) return 1 - lastm[k];
    if (streak[k] < hold[k]) return lastm[k];
    return 1 - lastm[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lastm[k]  = 1;
      streak[k] = 0;
      idlep[k]  = 1'b1;
      pend[k]   = -1;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int g;
      int t;
      logic [29:0] ea;
      logic [31:0] ed;
      logic [3:0]  em;
      logic        ew;
      string s;
      s = $sformatf("i%0d", k);
      g = rst_n ? pick(k) : -1;
      t = rst_n ? pend[k] : -1;
      ea = (g == 0) ? a0 : (g == 1) ? a1 : '0;
      ed = (g == 0) ? d0 : (g == 1) ? d1 : '0;
      em = (g == 0) ? m0 : (g == 1) ? m1 : '0;
      ew = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
      chk({s, ".gnt"}, {g0[k], g1[k]},
          {62'd0, g == 0, g == 1});
      chk({s, ".valid"}, vl[k], g >= 0);
      chk({s, ".addr"}, ma[k], ea);
      chk({s, ".data"}, md[k], ed);
      chk({s, ".mask"}, mm[k], em);
      chk({s, ".wren"}, wr[k], ew);
      chk({s, ".rvalid"}, {rv0[k], rv1[k]},
          {62'd0, t == 0, t == 1});
      chk({s, ".rdata0"}, rd0[k], (t == 0) ? sd : 32'd0);
      chk({s, ".rdata1"}, rd1[k], (t == 1) ? sd : 32'd0);
      if (!rst_n) begin
        lastm[k] = 1; streak[k] = 0;
        idlep[k] = 1'b1; pend[k] = -1;
      end else if (g < 0) begin
        idlep[k] = 1'b1; streak[k] = 0; pend[k] = -1;
      end else begin
        streak[k] = (!idlep[k] && g == lastm[k])
                  ? streak[k] + 1 : 1;
        lastm[k] = g;
        idlep[k] = 1'b0;
        pend[k]  = ew ? -1 : g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    step();
  endtask

  task automatic rnd_payload();
    a0 = 30'($urandom); a1 = 30'($urandom);
    d0 = $urandom; d1 = $urandom; sd = $urandom;
    m0 = 4'($urandom); m1 = 4'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0 = 1; r1 = 1; w0 = 0; w1 = 0;
    rnd_payload();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit r0, r1, e0, e1;
  } vec_t;
  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = '{1, 1, 1, 0};
    for (int i = 4; i < 8; i++) tbl[i] = '{1, 1, 0, 1};
    tbl[8]  = '{1, 1, 1, 0};
    tbl[9]  = '{1, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 1};
    tbl[13] = '{1, 1, 0, 1};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // burst pattern and idle-then-contend, all writes
    for (int i = 0; i < 14; i++) begin
      r0 = tbl[i].r0; r1 = tbl[i].r1;
      w0 = 1; w1 = 1;
      rnd_payload();
      settle();
      chk($sformatf("tbl%0d.g0", i), g0[0], tbl[i].e0);
      chk($sformatf("tbl%0d.g1", i), g1[0], tbl[i].e1);
      chk($sformatf("tbl%0d.valid", i), vl[0],
          tbl[i].e0 | tbl[i].e1);
      step();
    end

    // m1 single read, data returns next cycle
    do_reset();
    r0 = 0; r1 = 1; w1 = 0; a1 = 30'h10;
    settle();
    chk("rd.gnt1", g1[0], 1);
    chk("rd.addr", ma[0], 30'h10);
    step();
    r1 = 0; sd = 32'hDEADBEEF;
    settle();
    chk("rd.rvalid1", rv1[0], 1);
    chk("rd.rdata1", rd1[0], 32'hDEADBEEF);
    chk("rd.rvalid0", rv0[0], 0);
    step();
    settle();
    chk("rd.once", rv1[0], 0);
    step();

    // m0 write passthrough
    r0 = 1; r1 = 0; w0 = 1;
    a0 = 30'h3; d0 = 32'h12345678; m0 = 4'b0011;
    settle();
    chk("wr.addr", ma[0], 30'h3);
    chk("wr.data", md[0], 32'h12345678);
    chk("wr.mask", mm[0], 4'b0011);
    chk("wr.wren", wr[0], 1);
    step();
    r0 = 0;
    settle();
    chk("wr.norv", {rv0[0], rv1[0]}, 0);
    step();

    // read then reset: response must be dropped
    r0 = 1; r1 = 0; w0 = 0;
    tick();
    rst_n = 1'b0;
    r0 = 1; r1 = 1;
    settle();
    chk("rst.gnt", {g0, g1}, 0);
    chk("rst.rv", {rv0, rv1}, 0);
    chk("rst.valid", vl, 0);
    step();
    tick();
    rst_n = 1'b1;
    r0 = 1; r1 = 1; w0 = 1; w1 = 1;
    settle();
    chk("rel.gnt0", g0[0], 1);
    chk("rel.rv", {rv0[0], rv1[0]}, 0);
    step();

    // HOLD_MAX=1 alternating reads, incrementing slave data
    do_reset();
    r0 = 1; r1 = 1; w0 = 0; w1 = 0;
    for (int i = 0; i < 8; i++) begin
      sd = 32'h100 + 32'(i);
      settle();
      chk($sformatf("alt%0d.g0", i), g0[1], i % 2 == 0);
      if (i > 0) begin
        chk($sformatf("alt%0d.rv0", i), rv0[1], i % 2 == 1);
        chk($sformatf("alt%0d.rv1", i), rv1[1], i % 2 == 0);
      end
      step();
    end

    // random traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      r0 = 1'($urandom); r1 = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        r0 = 1; r1 = 1;
      end
      w0 = 1'($urandom); w1 = 1'($urandom);
      rnd_payload();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
